vga_line_prefetch_ctrl: RTL

// - Schedules frame-buffer burst reads so the next video line is in a ping-pong line buffer before the pixel pipeline needs it.
// - Watches the pixel-clock h/v counters and blanking flags from the timing generator.
// - During each horizontal blank it fetches line N+1; at vblank start it fetches line 0.
// - Issues req/ack/done bursts to the memory read port and flags deadline misses.

---
 rtl/vga_line_prefetch_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/vga_line_prefetch_ctrl.sv
// vga_line_prefetch_ctrl
// Schedules frame-buffer burst reads so that video line N+1 sits in a ping-pong line
// buffer before the pixel pipeline reaches it. Line N+1 is fetched during hblank.
// Line 0 is fetched at vblank start. A trigger that arrives while a line is still
// in flight is a deadline miss: the new line supersedes the stale one.
// Optional build macro VGA_PREFETCH_STATS_EN adds a saturating 16-bit underrun
// counter. Without it, o_underrun_cnt is tied to zero.
module vga_line_prefetch_ctrl #(
   parameter int unsigned H_ACTIVE    = 1920,
   parameter int unsigned V_ACTIVE    = 1080,
   parameter int unsigned BURST_LEN   = 64,
   parameter int unsigned LINE_STRIDE = 2048,
   parameter int unsigned BASE_ADDR   = 0,
   parameter int unsigned ADDR_W      = 24
) (
   input  logic              i_pclk,
   input  logic              i_rst,
   input  logic [11:0]       i_hcount,
   input  logic [11:0]       i_vcount,
   input  logic              i_vblnk,
   input  logic              i_enable,
   output logic              o_rd_req,
   output logic [ADDR_W-1:0] o_rd_addr,
   output logic [7:0]        o_rd_len,
   input  logic              i_rd_ack,
   input  logic              i_rd_done,
   output logic              o_buf_sel,
   output logic [11:0]       o_fetch_line,
   output logic              o_line_ready,
   output logic              o_busy,
   output logic              o_underrun,
   input  logic              i_clr_underrun,
   output logic [15:0]       o_underrun_cnt
);

   localparam int unsigned    N_BURSTS = (H_ACTIVE + BURST_LEN - 1) / BURST_LEN;
   localparam int unsigned    K_W      = (N_BURSTS > 1) ? $clog2(N_BURSTS) : 1;
   localparam logic [K_W-1:0] K_LAST   = K_W'(N_BURSTS - 1);
   localparam logic [11:0]    H_END    = 12'(H_ACTIVE);
   localparam logic [11:0]    V_END    = 12'(V_ACTIVE);
   localparam logic [11:0]    V_LAST   = 12'(V_ACTIVE - 1);

   typedef enum logic [1:0] {StIdle, StReq, StWaitDone} state_e;

   state_e         state_q;
   logic [K_W-1:0] k_q;
   logic           pend_q;
   logic [11:0]    pend_line_q;

   logic           trig_hb, trig_vb, trig, busy, last_burst;
   logic           burst_end, do_start, underrun_set;
   logic [11:0]    trig_line, start_line;

   // Start word address of burst k of a line, wrapped to the address width.
   function automatic logic [ADDR_W-1:0] burst_addr(input logic [11:0] line,
                                                    input logic [K_W-1:0] k);
      logic [63:0] a;
      a = 64'(BASE_ADDR) + 64'(line) * 64'(LINE_STRIDE) + 64'(k) * 64'(BURST_LEN);
      return a[ADDR_W-1:0];
   endfunction

   // Full bursts until the tail, which carries whatever pixels remain.
   function automatic logic [7:0] burst_len(input logic [K_W-1:0] k);
      int unsigned rem;
      rem = H_ACTIVE - 32'(k) * BURST_LEN;
      return (rem >= BURST_LEN) ? 8'(BURST_LEN) : 8'(rem);
   endfunction

   // Trigger decode and the burst-completion / line-start decisions.
   always_comb begin
      trig_hb      = (i_hcount == H_END) && !i_vblnk && (i_vcount < V_LAST);
      trig_vb      = (i_hcount == H_END) && (i_vcount == V_END);
      trig         = i_enable && (trig_hb || trig_vb);
      trig_line    = trig_vb ? 12'd0 : i_vcount + 12'd1;
      busy         = (state_q != StIdle);
      last_burst   = (k_q == K_LAST);
      // A done in the ack cycle completes the burst right away.
      burst_end    = ((state_q == StReq) && i_rd_ack && i_rd_done) ||
                     ((state_q == StWaitDone) && i_rd_done);
      // Newest trigger wins over an older pending one.
      start_line   = trig ? trig_line : pend_line_q;
      do_start     = ((state_q == StIdle) && trig) ||
                     (burst_end && i_enable && (pend_q || trig));
      underrun_set = trig && busy;
   end

   assign o_busy = busy;

   // Burst sequencing FSM with registered read-port and status outputs.
   always_ff @(posedge i_pclk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= StIdle;
         k_q          <= '0;
         pend_q       <= 1'b0;
         pend_line_q  <= '0;
         o_rd_req     <= 1'b0;
         o_rd_addr    <= '0;
         o_rd_len     <= '0;
         o_buf_sel    <= 1'b0;
         o_fetch_line <= '0;
         o_line_ready <= 1'b0;
         o_underrun   <= 1'b0;
      end else begin
         // A superseded line never reports ready.
         o_line_ready <= burst_end && last_burst && !pend_q;

         if (underrun_set) begin
            o_underrun <= 1'b1;
         end else if (i_clr_underrun) begin
            o_underrun <= 1'b0;
         end

         if (underrun_set && !do_start) begin
            pend_q      <= 1'b1;
            pend_line_q <= trig_line;
         end

         if (do_start) begin
            state_q      <= StReq;
            k_q          <= '0;
            pend_q       <= 1'b0;
            o_rd_req     <= 1'b1;
            o_fetch_line <= start_line;
            o_buf_sel    <= start_line[0];
            o_rd_addr    <= burst_addr(start_line, '0);
            o_rd_len     <= burst_len('0);
         end else if (burst_end) begin
            if (last_burst || !i_enable) begin
               state_q  <= StIdle;
               pend_q   <= 1'b0;
               o_rd_req <= 1'b0;
            end else begin
               state_q   <= StReq;
               k_q       <= k_q + K_W'(1);
               o_rd_req  <= 1'b1;
               o_rd_addr <= burst_addr(o_fetch_line, k_q + K_W'(1));
               o_rd_len  <= burst_len(k_q + K_W'(1));
            end
         end else if ((state_q == StReq) && i_rd_ack) begin
            state_q  <= StWaitDone;
            o_rd_req <= 1'b0;
         end
      end
   end

`ifdef VGA_PREFETCH_STATS_EN
   logic [15:0] cnt_q;

   // Saturating underrun counter; a new underrun beats a simultaneous clear.
   always_ff @(posedge i_pclk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else if (underrun_set) begin
         if (i_clr_underrun) begin
            cnt_q <= 16'd1;
         end else if (cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
         end
      end else if (i_clr_underrun) begin
         cnt_q <= '0;
      end
   end

   assign o_underrun_cnt = cnt_q;
`else
   assign o_underrun_cnt = 16'd0;
`endif

endmodule
